// File: rtl/neighbor_table_update_pkg.sv
// Shared definitions for the beacon-driven neighbor/sink table writer:
// memory map, table capacities and the controller state encoding.
package neighbor_table_update_pkg;

    localparam int DEF_WORD_WIDTH    = 16;
    localparam int DEF_MAX_NEIGHBORS = 64;
    localparam int DEF_MAX_SINKS     = 32;

    // Byte addresses, two bytes per word
    localparam int SINK_BASE     = 'h008;
    localparam int NID_BASE      = 'h048;
    localparam int CID_BASE      = 'h0C8;
    localparam int SINK_CNT_ADDR = 'h688;
    localparam int NBR_CNT_ADDR  = 'h68A;

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        LD_NCNT,
        SCAN_N,
        WR_NID,
        WR_CID,
        WR_NCNT,
        SINK_CHK,
        LD_SCNT,
        SCAN_S,
        WR_SINK,
        WR_SCNT,
        DONE
    } state_t;

endpackage

// File: rtl/neighbor_table_update_table_search.sv
// Linear table walker shared by the neighbor and sink phases: latches a base
// address and a capacity-clamped length, then steps one entry per cycle.
module table_search #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  init,
    input  logic                  step,
    input  logic [WORD_WIDTH-1:0] base,
    input  logic [WORD_WIDTH-1:0] count,
    input  logic [WORD_WIDTH-1:0] cap,
    input  logic [WORD_WIDTH-1:0] key,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic                  hit,
    output logic                  last,
    output logic [WORD_WIDTH-1:0] idx,
    output logic [WORD_WIDTH-1:0] next_addr
);

    logic [WORD_WIDTH-1:0] base_q;
    logic [WORD_WIDTH-1:0] limit_q;
    logic [WORD_WIDTH-1:0] i_q;
    logic [WORD_WIDTH-1:0] i_next;

    // Clamping the walk length to the capacity keeps every address in range
    // even when the stored count word is corrupt.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            base_q  <= '0;
            limit_q <= '0;
            i_q     <= '0;
        end else if (init) begin
            base_q  <= base;
            limit_q <= (count > cap) ? cap : count;
            i_q     <= '0;
        end else if (step) begin
            i_q <= i_next;
        end
    end

    assign i_next    = i_q + WORD_WIDTH'(1);
    assign hit       = (data_in == key);
    assign last      = (i_next >= limit_q);
    assign idx       = i_q;
    assign next_addr = base_q + (i_next << 1);

endmodule

// File: rtl/neighbor_table_update.sv
// Beacon-driven writer for the neighbor ID / cluster ID tables and the
// known-sink list in the shared single-port node memory.
module neighbor_table_update
    import neighbor_table_update_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int MAX_NEIGHBORS = DEF_MAX_NEIGHBORS,
    parameter int MAX_SINKS     = DEF_MAX_SINKS
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] rx_src_id,
    input  logic [WORD_WIDTH-1:0] rx_cluster_id,
    input  logic                  rx_is_sink,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] address,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  new_neighbor,
    output logic                  table_full,
    output state_t                state_dbg
);

    localparam logic [WORD_WIDTH-1:0] SINK_B  = WORD_WIDTH'(SINK_BASE);
    localparam logic [WORD_WIDTH-1:0] NID_B   = WORD_WIDTH'(NID_BASE);
    localparam logic [WORD_WIDTH-1:0] CID_B   = WORD_WIDTH'(CID_BASE);
    localparam logic [WORD_WIDTH-1:0] SCNT_A  = WORD_WIDTH'(SINK_CNT_ADDR);
    localparam logic [WORD_WIDTH-1:0] NCNT_A  = WORD_WIDTH'(NBR_CNT_ADDR);
    localparam logic [WORD_WIDTH-1:0] CAP_N   = WORD_WIDTH'(MAX_NEIGHBORS);
    localparam logic [WORD_WIDTH-1:0] CAP_S   = WORD_WIDTH'(MAX_SINKS);

    state_t                state;
    logic [WORD_WIDTH-1:0] src_q;
    logic [WORD_WIDTH-1:0] cluster_q;
    logic [WORD_WIDTH-1:0] cnt_q;
    logic [WORD_WIDTH-1:0] idx_q;
    logic                  sink_q;
    logic                  hit_q;

    logic                  in_load;
    logic                  in_sink;
    logic                  srch_step;
    logic                  srch_hit;
    logic                  srch_last;
    logic [WORD_WIDTH-1:0] srch_base;
    logic [WORD_WIDTH-1:0] srch_cap;
    logic [WORD_WIDTH-1:0] srch_idx;
    logic [WORD_WIDTH-1:0] srch_next;
    logic [WORD_WIDTH-1:0] miss_cnt;
    logic [WORD_WIDTH-1:0] miss_addr;
    logic                  miss_full;
    logic                  nbr_miss;
    logic                  sink_miss;

    assign in_load   = (state == LD_NCNT) || (state == LD_SCNT);
    assign in_sink   = (state == LD_SCNT) || (state == SCAN_S);
    assign srch_base = in_sink ? SINK_B : NID_B;
    assign srch_cap  = in_sink ? CAP_S : CAP_N;
    assign srch_step = ((state == SCAN_N) || (state == SCAN_S)) && !srch_hit && !srch_last;

    // The append slot equals the current count: fresh from memory in a load
    // state, from the latched copy once scanning.
    assign miss_cnt  = in_load ? data_in : cnt_q;
    assign miss_full = (miss_cnt >= srch_cap);
    assign miss_addr = srch_base + (miss_cnt << 1);
    assign nbr_miss  = ((state == LD_NCNT) && (data_in == '0)) ||
                       ((state == SCAN_N) && !srch_hit && srch_last);
    assign sink_miss = ((state == LD_SCNT) && (data_in == '0)) ||
                       ((state == SCAN_S) && !srch_hit && srch_last);

    table_search #(.WORD_WIDTH(WORD_WIDTH)) u_search (
        .clock     (clock),
        .nrst      (nrst),
        .init      (in_load),
        .step      (srch_step),
        .base      (srch_base),
        .count     (data_in),
        .cap       (srch_cap),
        .key       (src_q),
        .data_in   (data_in),
        .hit       (srch_hit),
        .last      (srch_last),
        .idx       (srch_idx),
        .next_addr (srch_next)
    );

    // en arms from IDLE/DONE; start is a single-cycle request honoured only in
    // ARM, with rx_* captured on that same edge. done holds until re-armed.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            address      <= NCNT_A;
            wr_en        <= 1'b0;
            data_out     <= '0;
            done         <= 1'b0;
            new_neighbor <= 1'b0;
            table_full   <= 1'b0;
            src_q        <= '0;
            cluster_q    <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            sink_q       <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: if (en) state <= ARM;
                ARM: if (start) begin
                    src_q        <= rx_src_id;
                    cluster_q    <= rx_cluster_id;
                    sink_q       <= rx_is_sink;
                    hit_q        <= 1'b0;
                    new_neighbor <= 1'b0;
                    table_full   <= 1'b0;
                    address      <= NCNT_A;
                    state        <= LD_NCNT;
                end
                LD_NCNT, SCAN_N: begin
                    if (state == LD_NCNT) cnt_q <= data_in;
                    if (nbr_miss) begin
                        hit_q <= 1'b0;
                        if (miss_full) begin
                            table_full <= 1'b1;
                            state      <= SINK_CHK;
                        end else begin
                            idx_q        <= miss_cnt;
                            new_neighbor <= 1'b1;
                            address      <= miss_addr;
                            data_out     <= src_q;
                            wr_en        <= 1'b1;
                            state        <= WR_NID;
                        end
                    end else if (state == LD_NCNT) begin
                        address <= NID_B;
                        state   <= SCAN_N;
                    end else if (srch_hit) begin
                        hit_q    <= 1'b1;
                        idx_q    <= srch_idx;
                        address  <= CID_B + (srch_idx << 1);
                        data_out <= cluster_q;
                        wr_en    <= 1'b1;
                        state    <= WR_CID;
                    end else begin
                        address <= srch_next;
                    end
                end
                WR_NID: begin
                    address  <= CID_B + (idx_q << 1);
                    data_out <= cluster_q;
                    wr_en    <= 1'b1;
                    state    <= WR_CID;
                end
                WR_CID: begin
                    if (hit_q) begin
                        state <= SINK_CHK;
                    end else begin
                        address  <= NCNT_A;
                        data_out <= cnt_q + WORD_WIDTH'(1);
                        wr_en    <= 1'b1;
                        state    <= WR_NCNT;
                    end
                end
                WR_NCNT: state <= SINK_CHK;
                SINK_CHK: begin
                    if (!sink_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        address <= SCNT_A;
                        state   <= LD_SCNT;
                    end
                end
                LD_SCNT, SCAN_S: begin
                    if (state == LD_SCNT) cnt_q <= data_in;
                    if (sink_miss) begin
                        if (miss_full) begin
                            table_full <= 1'b1;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            address  <= miss_addr;
                            data_out <= src_q;
                            wr_en    <= 1'b1;
                            state    <= WR_SINK;
                        end
                    end else if (state == LD_SCNT) begin
                        address <= SINK_B;
                        state   <= SCAN_S;
                    end else if (srch_hit) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        address <= srch_next;
                    end
                end
                WR_SINK: begin
                    address  <= SCNT_A;
                    data_out <= cnt_q + WORD_WIDTH'(1);
                    wr_en    <= 1'b1;
                    state    <= WR_SCNT;
                end
                WR_SCNT: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: if (en) begin
                    done         <= 1'b0;
                    new_neighbor <= 1'b0;
                    table_full   <= 1'b0;
                    state        <= ARM;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule
